ir_fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer sitting in front of ir_cache. Owns the PC and drives ir_addr.

---
 rtl/ir_fetch_ctrl_if.sv | 27 ++
 rtl/ir_fetch_ctrl.sv | 143 ++++++++++++++
 tb/tb_ir_fetch_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ir_fetch_ctrl_if.sv
// Fetch-controller bus: cache address/data, decode handshake, redirect and halt control.
// Decode handshake: a word moves when inst_valid & inst_ready are both high at posedge;
// inst/inst_pc hold steady while inst_valid=1 and inst_ready=0.
interface ir_fetch_ctrl_if #(
  parameter int WORD_WIDTH = 32
);
  logic [WORD_WIDTH-1:0] ir_addr;
  logic [WORD_WIDTH-1:0] ir_data;
  logic [WORD_WIDTH-1:0] inst;
  logic [WORD_WIDTH-1:0] inst_pc;
  logic                  inst_valid;
  logic                  inst_ready;
  logic                  redirect_valid;
  logic [WORD_WIDTH-1:0] redirect_pc;
  logic                  halt;
  logic                  halted;

  modport master (
    output ir_addr, inst, inst_pc, inst_valid, halted,
    input  ir_data, inst_ready, redirect_valid, redirect_pc, halt
  );

  modport slave (
    input  ir_addr, inst, inst_pc, inst_valid, halted,
    output ir_data, inst_ready, redirect_valid, redirect_pc, halt
  );
endinterface

// File: rtl/ir_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, hides the cache's one-cycle read latency
// behind a 2-entry buffer, and handles boot delay, redirects and halt.
module ir_fetch_ctrl #(
  parameter int                    WORD_WIDTH  = 32,
  parameter logic [WORD_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    BOOT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  ir_fetch_ctrl_if.master   bus,
  output logic [1:0]        dbg_state
);
  localparam int CW = $clog2(BOOT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         boot_cnt_q, boot_cnt_d;
  logic [WORD_WIDTH-1:0] pc_q, pc_d;
  logic [WORD_WIDTH-1:0] tag_q, tag_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            count_q, count_d;
  logic [WORD_WIDTH-1:0] data0_q, data0_d, pc0_q, pc0_d;
  logic [WORD_WIDTH-1:0] data1_q, data1_d, pc1_q, pc1_d;
  logic                  halted_q, halted_d;

  logic                  redirect;
  logic                  push;
  logic                  pop;
  logic                  issue;
  logic [2:0]            occ;

  always_comb begin
    redirect = bus.redirect_valid;
    pop      = (count_q != 2'd0) && !redirect && bus.inst_ready;
    // A redirect squashes the word returning this cycle by simply not pushing it.
    push     = inflight_q && !redirect;
    // Credit: slots already owed (buffered + returning) after this cycle's pop.
    occ      = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue    = (state_q == S_RUN) && !redirect && !bus.halt && (occ < 3'd2);

    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    case (state_q)
      S_BOOT: begin
        if (boot_cnt_q != '0) boot_cnt_d = boot_cnt_q - CW'(1);
        if (boot_cnt_q <= CW'(1)) state_d = S_RUN;
      end
      S_RUN:   if (!redirect && bus.halt) state_d = S_HALT;
      S_HALT:  if (redirect) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
    halted_d = (state_d == S_HALT);

    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = issue;
    if (redirect) begin
      pc_d = bus.redirect_pc & ~(WORD_WIDTH'(3));
    end else if (issue) begin
      pc_d  = pc_q + WORD_WIDTH'(4);
      tag_d = pc_q;
    end

    count_d = count_q;
    data0_d = data0_q;
    pc0_d   = pc0_q;
    data1_d = data1_q;
    pc1_d   = pc1_q;
    if (redirect) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            data0_d = bus.ir_data;
            pc0_d   = tag_q;
          end else begin
            data1_d = bus.ir_data;
            pc1_d   = tag_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          data0_d = data1_q;
          pc0_d   = pc1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            data0_d = bus.ir_data;
            pc0_d   = tag_q;
          end else begin
            data0_d = data1_q;
            pc0_d   = pc1_q;
            data1_d = bus.ir_data;
            pc1_d   = tag_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_BOOT;
      boot_cnt_q <= CW'(BOOT_CYCLES);
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      data0_q    <= '0;
      pc0_q      <= '0;
      data1_q    <= '0;
      pc1_q      <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      data0_q    <= data0_d;
      pc0_q      <= pc0_d;
      data1_q    <= data1_d;
      pc1_q      <= pc1_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.ir_addr    = pc_q;
  assign bus.inst       = data0_q;
  assign bus.inst_pc    = pc0_q;
  assign bus.inst_valid = (count_q != 2'd0) && !redirect;
  assign bus.halted     = halted_q;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_ir_fetch_ctrl.sv
// Bench for ir_fetch_ctrl: cycle table for boot/backpressure/redirect timing, then
// scoreboarded sequences for halt, wrap-around and mid-stream reset.
module tb_ir_fetch_ctrl;
  localparam int WW = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] dbg_state;

  ir_fetch_ctrl_if #(.WORD_WIDTH(WW)) intf ();

  ir_fetch_ctrl #(
    .WORD_WIDTH (WW),
    .RESET_PC   (32'h0),
    .BOOT_CYCLES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (intf.master),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Cache memory contents: odd multiplier makes every address map to a distinct word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  always @(posedge clk) intf.ir_data <= mem_word(intf.ir_addr);

  int n_checks = 0;
  int n_fail   = 0;
  logic sb_on  = 1'b0;
  logic [WW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted word must be the next expected pc with its memory word.
  always @(negedge clk) begin
    if (sb_on && rst && intf.inst_valid && intf.inst_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc %h expected no delivery", intf.inst_pc);
      end else begin
        logic [WW-1:0] e;
        e = exp_q.pop_front();
        check("sb_pc", intf.inst_pc, e);
        check("sb_inst", intf.inst, mem_word(e));
      end
    end
  end

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rpc,
                              input logic [31:0] addr, input logic v, input logic [31:0] pc);
    vec_t t;
    t.rdy = r; t.rv = rv; t.rpc = rpc;
    t.exp_addr = addr; t.exp_valid = v; t.exp_pc = pc;
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entry i is driven at the start of cycle ci and checked mid-cycle.
  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      intf.inst_ready     = tbl[i].rdy;
      intf.redirect_valid = tbl[i].rv;
      intf.redirect_pc    = tbl[i].rpc;
      @(negedge clk);
      check($sformatf("c%0d_ir_addr", i), intf.ir_addr, tbl[i].exp_addr);
      check($sformatf("c%0d_valid", i), 32'(intf.inst_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) begin
        check($sformatf("c%0d_inst_pc", i), intf.inst_pc, tbl[i].exp_pc);
        check($sformatf("c%0d_inst", i), intf.inst, mem_word(tbl[i].exp_pc));
      end
      check($sformatf("c%0d_halted", i), 32'(intf.halted), 32'h0);
      step();
    end
  endtask

  task automatic drain(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      step();
      if (exp_q.size() == 0) break;
    end
    if (i == budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i <= 6; i++) tbl[i] = mk(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tbl[3] = mk(1'b1, 1'b0, 32'h0, 32'h04, 1'b0, 32'h0);
    tbl[4] = mk(1'b1, 1'b0, 32'h0, 32'h08, 1'b1, 32'h0);
    tbl[5] = mk(1'b1, 1'b0, 32'h0, 32'h0C, 1'b1, 32'h4);
    tbl[6] = mk(1'b1, 1'b0, 32'h0, 32'h10, 1'b1, 32'h8);
    for (int i = 7; i <= 12; i++) tbl[i] = mk(1'b0, 1'b0, 32'h0, 32'h14, 1'b1, 32'h0C);
    tbl[13] = mk(1'b1, 1'b0, 32'h0,  32'h14, 1'b1, 32'h0C);
    tbl[14] = mk(1'b1, 1'b0, 32'h0,  32'h18, 1'b1, 32'h10);
    tbl[15] = mk(1'b1, 1'b0, 32'h0,  32'h1C, 1'b1, 32'h14);
    tbl[16] = mk(1'b1, 1'b1, 32'h43, 32'h20, 1'b0, 32'h0);
    tbl[17] = mk(1'b1, 1'b0, 32'h0,  32'h40, 1'b0, 32'h0);
    tbl[18] = mk(1'b1, 1'b0, 32'h0,  32'h44, 1'b0, 32'h0);
    tbl[19] = mk(1'b1, 1'b0, 32'h0,  32'h48, 1'b1, 32'h40);
    tbl[20] = mk(1'b1, 1'b0, 32'h0,  32'h4C, 1'b1, 32'h44);

    intf.inst_ready     = 1'b0;
    intf.redirect_valid = 1'b0;
    intf.redirect_pc    = 32'h0;
    intf.halt           = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_ir_addr", intf.ir_addr, 32'h0);
    check("rst_valid", 32'(intf.inst_valid), 32'h0);
    check("rst_inst", intf.inst, 32'h0);
    check("rst_inst_pc", intf.inst_pc, 32'h0);
    check("rst_halted", 32'(intf.halted), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);

    // Boot, backpressure and redirect-to-0x43 timing
    rst = 1'b1;
    run_table(0, 20);

    // Halt: three fetches after redirect to 0x200, halt raised in the fourth cycle
    intf.redirect_valid = 1'b1;
    intf.redirect_pc    = 32'h200;
    intf.inst_ready     = 1'b1;
    exp_q.delete();
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    exp_q.push_back(32'h208);
    sb_on = 1'b1;
    step();
    intf.redirect_valid = 1'b0;
    step();
    step();
    step();
    intf.halt = 1'b1;
    step();
    @(negedge clk);
    check("halt_halted", 32'(intf.halted), 32'h1);
    check("halt_state", 32'(dbg_state), 32'h2);
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      check($sformatf("halt_addr_%0d", i), intf.ir_addr, 32'h20C);
    end
    check("halt_drained", exp_q.size(), 32'h0);

    // Redirect while halt is still high: redirect wins, halt dropped next cycle
    step();
    intf.redirect_valid = 1'b1;
    intf.redirect_pc    = 32'h100;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(4 * i));
    @(negedge clk);
    check("resume_gate_valid", 32'(intf.inst_valid), 32'h0);
    step();
    intf.redirect_valid = 1'b0;
    intf.halt           = 1'b0;
    @(negedge clk);
    check("resume_halted", 32'(intf.halted), 32'h0);
    check("resume_state", 32'(dbg_state), 32'h1);
    check("resume_ir_addr", intf.ir_addr, 32'h100);
    drain(20);
    intf.inst_ready = 1'b0;

    // Wrap-around past the top of the address space
    step();
    intf.redirect_valid = 1'b1;
    intf.redirect_pc    = 32'hFFFF_FFFC;
    intf.inst_ready     = 1'b1;
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    step();
    intf.redirect_valid = 1'b0;
    @(negedge clk);
    check("wrap_ir_addr", intf.ir_addr, 32'hFFFF_FFFC);
    drain(20);
    intf.inst_ready = 1'b0;

    // Asynchronous reset mid-stream, then the boot sequence again
    sb_on = 1'b0;
    intf.inst_ready = 1'b1;
    repeat ($urandom_range(3, 6)) step();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(intf.inst_valid), 32'h0);
    check("mid_rst_ir_addr", intf.ir_addr, 32'h0);
    check("mid_rst_halted", 32'(intf.halted), 32'h0);
    check("mid_rst_state", 32'(dbg_state), 32'h0);
    step();
    step();
    rst = 1'b1;
    run_table(0, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
